// File: rtl/hazard3_mul_arbiter_pkg.sv
// Shared definitions for the hazard3 multiplier arbiter: slot states, multiply
// opcodes (core M-extension low funct3 bits) and the tag-width helper.
package hazard3_mul_arbiter_pkg;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_BUSY = 2'd1,
      SLOT_DONE = 2'd2
   } slot_e;

   localparam logic [1:0] MULOP_MUL    = 2'd0;
   localparam logic [1:0] MULOP_MULH   = 2'd1;
   localparam logic [1:0] MULOP_MULHSU = 2'd2;
   localparam logic [1:0] MULOP_MULHU  = 2'd3;

   // Tag wide enough to name any requester; never narrower than one bit.
   function automatic int unsigned tag_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hazard3_rr_pick.sv
// Round-robin one-hot picker: first set bit of req at or after ptr, wrapping.
// Reusable by any shared-resource arbiter; ptr must be below N.
module hazard3_rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned W_IDX = 1
) (
   input  logic [N-1:0]     req,
   input  logic [W_IDX-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [W_IDX-1:0] idx,
   output logic             any
);

   int unsigned      pos;
   logic [W_IDX-1:0] pos_idx;

   always_comb begin
      gnt     = '0;
      idx     = '0;
      any     = 1'b0;
      pos     = 0;
      pos_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         pos_idx = W_IDX'(pos);
         if (!any && req[pos_idx]) begin
            any          = 1'b1;
            gnt[pos_idx] = 1'b1;
            idx          = pos_idx;
         end
      end
   end

endmodule

// File: rtl/hazard3_mul_arbiter.sv
// Shares one 1-cycle multiplier between N_REQ requesters with round-robin grant
// and per-requester response slots. Define HAZARD3_MUL_ARB_BYPASS_EN for 1-cycle responses.
module hazard3_mul_arbiter
   import hazard3_mul_arbiter_pkg::*;
#(
   parameter int unsigned W_DATA  = 32,
   parameter int unsigned W_MULOP = 2,
   parameter int unsigned N_REQ   = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_vld,
   output logic [N_REQ-1:0]            req_rdy,
   input  logic [N_REQ*W_MULOP-1:0]    req_op,
   input  logic [N_REQ*W_DATA-1:0]     req_a,
   input  logic [N_REQ*W_DATA-1:0]     req_b,
   output logic [N_REQ-1:0]            resp_vld,
   input  logic [N_REQ-1:0]            resp_rdy,
   output logic [N_REQ*W_DATA-1:0]     resp_result,
   output logic [W_MULOP-1:0]          mul_op,
   output logic                        mul_op_vld,
   output logic [W_DATA-1:0]           mul_op_a,
   output logic [W_DATA-1:0]           mul_op_b,
   input  logic [W_DATA-1:0]           mul_result,
   input  logic                        mul_result_vld
);

   localparam int unsigned W_TAG = tag_w(N_REQ);

   slot_e             slot_q   [N_REQ];
   slot_e             slot_d   [N_REQ];
   logic [W_DATA-1:0] result_q [N_REQ];
   logic [W_DATA-1:0] result_d [N_REQ];
   logic [W_TAG-1:0]  rr_ptr_q, rr_ptr_d;
   logic [W_TAG-1:0]  issue_tag_q, issue_tag_d;

   logic [N_REQ-1:0]  eligible;
   logic [N_REQ-1:0]  grant;
   logic [W_TAG-1:0]  grant_idx;
   logic              grant_any;
   logic [W_TAG-1:0]  sel;
   logic [N_REQ-1:0]  ret_hit;

   // Grant is suppressed while rst is high so req_rdy stays low during reset.
   always_comb begin
      eligible = '0;
      ret_hit  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         eligible[i] = req_vld[i] && (slot_q[i] == SLOT_IDLE) && !rst;
         ret_hit[i]  = mul_result_vld && (issue_tag_q == W_TAG'(i))
                       && (slot_q[i] == SLOT_BUSY);
      end
   end

   hazard3_rr_pick #(
      .N     (N_REQ),
      .W_IDX (W_TAG)
   ) u_pick (
      .req (eligible),
      .ptr (rr_ptr_q),
      .gnt (grant),
      .idx (grant_idx),
      .any (grant_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            slot_q[i]   <= SLOT_IDLE;
            result_q[i] <= '0;
         end
         rr_ptr_q    <= '0;
         issue_tag_q <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            slot_q[i]   <= slot_d[i];
            result_q[i] <= result_d[i];
         end
         rr_ptr_q    <= rr_ptr_d;
         issue_tag_q <= issue_tag_d;
      end
   end

   // Result is only valid the cycle after issue, so capture happens on ret_hit alone.
   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         slot_d[i]   = slot_q[i];
         result_d[i] = result_q[i];
         case (slot_q[i])
            SLOT_IDLE: begin
               if (grant[i]) begin
                  slot_d[i] = SLOT_BUSY;
               end
            end
            SLOT_BUSY: begin
               if (ret_hit[i]) begin
                  result_d[i] = mul_result;
`ifdef HAZARD3_MUL_ARB_BYPASS_EN
                  slot_d[i]   = resp_rdy[i] ? SLOT_IDLE : SLOT_DONE;
`else
                  slot_d[i]   = SLOT_DONE;
`endif
               end
            end
            SLOT_DONE: begin
               if (resp_rdy[i]) begin
                  slot_d[i] = SLOT_IDLE;
               end
            end
            default: slot_d[i] = SLOT_IDLE;
         endcase
      end

      rr_ptr_d    = rr_ptr_q;
      issue_tag_d = issue_tag_q;
      if (grant_any) begin
         rr_ptr_d    = (grant_idx == W_TAG'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
         issue_tag_d = grant_idx;
      end
   end

   always_comb begin
      req_rdy    = grant;
      mul_op_vld = grant_any;
      sel        = grant_any ? grant_idx : '0;
      mul_op     = req_op[32'(sel)*W_MULOP +: W_MULOP];
      mul_op_a   = req_a[32'(sel)*W_DATA +: W_DATA];
      mul_op_b   = req_b[32'(sel)*W_DATA +: W_DATA];

      resp_vld    = '0;
      resp_result = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         resp_vld[i]                     = (slot_q[i] == SLOT_DONE);
         resp_result[i*W_DATA +: W_DATA] = result_q[i];
`ifdef HAZARD3_MUL_ARB_BYPASS_EN
         if (ret_hit[i]) begin
            resp_vld[i]                     = 1'b1;
            resp_result[i*W_DATA +: W_DATA] = mul_result;
         end
`endif
      end
   end

endmodule

// File: tb/tb_hazard3_mul_arbiter.sv
// Directed bench for hazard3_mul_arbiter with a 1-cycle behavioural multiplier.
// Builds with or without HAZARD3_MUL_ARB_BYPASS_EN.
module tb_hazard3_mul_arbiter;
   import hazard3_mul_arbiter_pkg::*;

   localparam int unsigned N = 2;
   localparam int unsigned W = 32;
`ifdef HAZARD3_MUL_ARB_BYPASS_EN
   localparam int EXP_STRAY = 0;
`else
   localparam int EXP_STRAY = 2;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req_vld, req_rdy, resp_vld, resp_rdy;
   logic [N*2-1:0]  req_op;
   logic [N*W-1:0]  req_a, req_b, resp_result;
   logic [1:0]      mul_op;
   logic            mul_op_vld;
   logic [W-1:0]    mul_op_a, mul_op_b, mul_result;
   logic            mul_result_vld;

   logic [W-1:0]    mres = '0;
   logic            mres_vld = 1'b0;
   logic            inj_vld = 1'b0;
   logic [N-1:0]    busy_m = '0;
   int unsigned     tag_m = 0;
   int              n_stray = 0;
   int              n_tests = 0;
   int              n_fail = 0;

   assign mul_result     = mres;
   assign mul_result_vld = mres_vld | inj_vld;

   hazard3_mul_arbiter #(
      .W_DATA  (W),
      .W_MULOP (2),
      .N_REQ   (N)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_vld        (req_vld),
      .req_rdy        (req_rdy),
      .req_op         (req_op),
      .req_a          (req_a),
      .req_b          (req_b),
      .resp_vld       (resp_vld),
      .resp_rdy       (resp_rdy),
      .resp_result    (resp_result),
      .mul_op         (mul_op),
      .mul_op_vld     (mul_op_vld),
      .mul_op_a       (mul_op_a),
      .mul_op_b       (mul_op_b),
      .mul_result     (mul_result),
      .mul_result_vld (mul_result_vld)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mulf(input logic [1:0] op, input logic [W-1:0] a, b);
      logic [63:0] sa, ua, sb, ub, p;
      sa = {{32{a[31]}}, a};
      ua = {32'b0, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (op)
         MULOP_MUL:    begin p = ua * ub; return p[31:0];  end
         MULOP_MULH:   begin p = sa * sb; return p[63:32]; end
         MULOP_MULHSU: begin p = sa * ub; return p[63:32]; end
         default:      begin p = ua * ub; return p[63:32]; end
      endcase
   endfunction

   // Multiplier model and stray-result monitor
   always @(posedge clk) begin
      mres     <= mulf(mul_op, mul_op_a, mul_op_b);
      mres_vld <= mul_op_vld;
      if (mul_result_vld) begin
         if (busy_m[tag_m] && !rst) busy_m[tag_m] <= 1'b0;
         else n_stray <= n_stray + 1;
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (req_vld[i] && req_rdy[i]) begin
            busy_m[i] <= 1'b1;
            tag_m     <= i;
         end
      end
      if (rst) begin
         busy_m <= '0;
         tag_m  <= 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int unsigned i, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      req_op[i*2 +: 2] = op;
      req_a[i*W +: W]  = a;
      req_b[i*W +: W]  = b;
   endtask

   initial begin
      req_vld = '0; resp_rdy = '0; req_op = '0; req_a = '0; req_b = '0;
      #1 rst = 1'b1;
      req_vld = 2'b11;
      set_req(0, MULOP_MUL, 32'd1, 32'd1);
      #2;
      check("rst_req_rdy", req_rdy, 2'b00);
      check("rst_mul_vld", mul_op_vld, 1'b0);
      check("rst_resp_vld", resp_vld, 2'b00);
      check("rst_resp_res", resp_result, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      req_vld = '0;
      cyc();

`ifdef HAZARD3_MUL_ARB_BYPASS_EN
      resp_rdy = 2'b01;
      set_req(0, MULOP_MUL, 32'd3, 32'd5);
      req_vld = 2'b01; #2;
      check("byp_acc", req_rdy, 2'b01);
      cyc(); req_vld = 2'b00; #2;
      check("byp_vld", resp_vld, 2'b01);
      check("byp_res", resp_result[31:0], 32'd15);
      cyc(); req_vld = 2'b01; #2;
      check("byp_reacc", req_rdy, 2'b01);
      check("byp_idle", resp_vld, 2'b00);
      cyc(); req_vld = 2'b00; #2;
      check("byp_vld2", resp_vld, 2'b01);
      check("byp_res2", resp_result[31:0], 32'd15);
      cyc(); #2;
      check("byp_done", resp_vld, 2'b00);
`else
      // single op
      set_req(0, MULOP_MUL, 32'd7, 32'd6);
      req_vld = 2'b01; #2;
      check("t1_rdy", req_rdy, 2'b01);
      check("t1_issue", mul_op_vld, 1'b1);
      check("t1_a", mul_op_a, 32'd7);
      check("t1_op", mul_op, MULOP_MUL);
      cyc(); req_vld = 2'b00; #2;
      check("t1_lat", resp_vld, 2'b00);
      cyc(); #2;
      check("t1_vld", resp_vld, 2'b01);
      check("t1_res", resp_result[31:0], 32'd42);
      resp_rdy = 2'b01;
      cyc(); #2;
      check("t1_clr", resp_vld, 2'b00);
      req_vld = 2'b01; #2;
      check("t1_idle", req_rdy, 2'b01);
      req_vld = 2'b00;
      rst = 1'b1; #2; rst = 1'b0;
      cyc();

      // contention from rr_ptr = 0
      resp_rdy = 2'b11;
      set_req(0, MULOP_MUL, 32'd3, 32'd4);
      set_req(1, MULOP_MUL, 32'd5, 32'd6);
      req_vld = 2'b11; #2;
      check("t2_g0", req_rdy, 2'b01);
      check("t2_a0", mul_op_a, 32'd3);
      cyc(); #2;
      check("t2_g1", req_rdy, 2'b10);
      check("t2_a1", mul_op_a, 32'd5);
      check("t2_b1", mul_op_b, 32'd6);
      cyc(); req_vld = 2'b00; #2;
      check("t2_v0", resp_vld, 2'b01);
      check("t2_r0", resp_result[31:0], 32'd12);
      cyc(); #2;
      check("t2_v1", resp_vld, 2'b10);
      check("t2_r1", resp_result[63:32], 32'd30);
      cyc(); #2;
      check("t2_idle", resp_vld, 2'b00);

      // signed / unsigned high products
      set_req(1, MULOP_MULH, 32'hFFFF_FFFF, 32'h2);
      req_vld = 2'b10; #2;
      check("t3_rdy1", req_rdy, 2'b10);
      check("t3_op", mul_op, MULOP_MULH);
      cyc(); req_vld = 2'b00;
      cyc(); #2;
      check("t3_v1", resp_vld, 2'b10);
      check("t3_mulh", resp_result[63:32], 32'hFFFF_FFFF);
      cyc();
      set_req(0, MULOP_MULHU, 32'hFFFF_FFFF, 32'h2);
      req_vld = 2'b01; #2;
      check("t3_rdy0", req_rdy, 2'b01);
      cyc(); req_vld = 2'b00;
      cyc(); #2;
      check("t3_v0", resp_vld, 2'b01);
      check("t3_mulhu", resp_result[31:0], 32'd1);
      cyc();

      // backpressure on requester 0 while requester 1 keeps going
      resp_rdy = 2'b00;
      set_req(0, MULOP_MUL, 32'd9, 32'd9);
      req_vld = 2'b01;
      cyc(); req_vld = 2'b00;
      cyc();
      set_req(1, MULOP_MUL, 32'd2, 32'd8);
      req_vld = 2'b11; resp_rdy = 2'b10;
      for (int k = 0; k < 5; k++) begin
         #2;
         check("t4_hold_vld", resp_vld[0], 1'b1);
         check("t4_hold_res", resp_result[31:0], 32'd81);
         check("t4_no_rdy0", req_rdy[0], 1'b0);
         if (k == 0) check("t4_g1", req_rdy, 2'b10);
         if (k == 2) begin
            check("t4_v1", resp_vld[1], 1'b1);
            check("t4_r1", resp_result[63:32], 32'd16);
         end
         cyc();
      end
      req_vld = 2'b00; resp_rdy = 2'b11; #2;
      check("t4_both", resp_vld, 2'b11);
      cyc(); #2;
      check("t4_idle", resp_vld, 2'b00);

      // reset while the op is in flight
      set_req(0, MULOP_MUL, 32'd10, 32'd10);
      req_vld = 2'b01; #2;
      check("t5_acc", req_rdy, 2'b01);
      cyc(); req_vld = 2'b00; rst = 1'b1; #2;
      check("t5_rst_vld", resp_vld, 2'b00);
      check("t5_rst_res", resp_result, 64'd0);
      check("t5_rst_issue", mul_op_vld, 1'b0);
      cyc(); rst = 1'b0; inj_vld = 1'b1; #2;
      check("t5_drop0", resp_vld, 2'b00);
      cyc(); inj_vld = 1'b0; #2;
      check("t5_drop1", resp_vld, 2'b00);
      cyc(); #2;
      check("t5_drop2", resp_vld, 2'b00);
      set_req(0, MULOP_MUL, 32'd4, 32'd5);
      req_vld = 2'b01; #2;
      check("t5_reacc", req_rdy, 2'b01);
      cyc(); req_vld = 2'b00;
      cyc(); #2;
      check("t5_v0", resp_vld, 2'b01);
      check("t5_r0", resp_result[31:0], 32'd20);
      cyc();
`endif
      cyc();
      check("stray_results", n_stray, EXP_STRAY);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
